// File: rtl/vehicle_detect.sv
// -----------------------------------------------------------------------------
// vehicle_detect
//
// Conditions the four raw inductive-loop inputs of the intersection into clean,
// one-pulse-per-vehicle detect strobes for the downstream car counters.
// Each of the four channels is independent and contains:
//   - a 2-flop synchronizer for the asynchronous loop input
//   - a debounce FSM (IDLE / QUAL_ON / PRESENT / QUAL_OFF) that accepts an
//     edge only after DEB_CYCLES identical synchronized samples
//   - a fixed-width pulse generator fired on entry to PRESENT
//   - a stuck-loop watchdog that flags a loop occupied for STUCK_CYCLES
//
// Ports
//   clock                      system clock, rising edge
//   rst_n                      asynchronous active-low reset
//   sensor_ns/sn/ew/we         raw loop inputs, high = metal present
//   detect_ns/sn/ew/we         clean vehicle pulses, PULSE_CYCLES wide
//   fault[3:0]                 stuck-loop flags, {we, ew, sn, ns}
//   occupied[3:0]              debounced occupancy, {we, ew, sn, ns}
//
// Per-channel FSM state is visible hierarchically as g_ch[i].state.
// -----------------------------------------------------------------------------
module vehicle_detect #(
  parameter int DEB_CYCLES   = 16,
  parameter int PULSE_CYCLES = 4,
  parameter int STUCK_CYCLES = 1000,
  parameter int CW           = 16
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       sensor_ns,
  input  logic       sensor_sn,
  input  logic       sensor_ew,
  input  logic       sensor_we,
  output logic       detect_ns,
  output logic       detect_sn,
  output logic       detect_ew,
  output logic       detect_we,
  output logic [3:0] fault,
  output logic [3:0] occupied
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL_ON  = 2'd1,
    PRESENT  = 2'd2,
    QUAL_OFF = 2'd3
  } state_t;

  // The debounce counter holds the number of agreeing samples seen so far;
  // the edge is accepted on the sample that would bring it to DEB_CYCLES.
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LEN  = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] STUCK_MAX  = CW'(STUCK_CYCLES);
  localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYCLES - 1);

  logic [3:0] raw;
  logic [3:0] detect;

  assign raw       = {sensor_we, sensor_ew, sensor_sn, sensor_ns};
  assign detect_ns = detect[0];
  assign detect_sn = detect[1];
  assign detect_ew = detect[2];
  assign detect_we = detect[3];

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic          sync_meta;
    logic          sync_s;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] pulse_cnt;
    logic [CW-1:0] stuck_cnt;
    logic          fault_q;
    logic          occ;
    logic          enter_present;
    logic          enter_idle;
    logic          stuck_hit;

    // Two-flop synchronizer; sync_s is the only copy of the input used below.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        sync_meta <= 1'b0;
        sync_s    <= 1'b0;
      end else begin
        sync_meta <= raw[i];
        sync_s    <= sync_meta;
      end
    end

    // State register
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
      end else begin
        state <= state_next;
      end
    end

    // Next-state logic
    always_comb begin
      state_next = state;
      case (state)
        IDLE: begin
          if (sync_s) state_next = QUAL_ON;
        end
        QUAL_ON: begin
          if (!sync_s)                  state_next = IDLE;
          else if (deb_cnt == DEB_LAST) state_next = PRESENT;
        end
        PRESENT: begin
          if (!sync_s) state_next = QUAL_OFF;
        end
        QUAL_OFF: begin
          // A short dropout returns to PRESENT: same vehicle, no new pulse.
          if (sync_s)                   state_next = PRESENT;
          else if (deb_cnt == DEB_LAST) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    // Output / strobe decode
    always_comb begin
      occ           = (state == PRESENT) || (state == QUAL_OFF);
      enter_present = (state == QUAL_ON) && (state_next == PRESENT);
      enter_idle    = (state != IDLE) && (state_next == IDLE);
      stuck_hit     = occ && (stuck_cnt == STUCK_LAST);
    end

    // Debounce counter: counts agreeing samples while qualifying, restarts at 1
    // on entering a qualify state, and is 0 elsewhere. It never exceeds
    // DEB_CYCLES-1 because the FSM leaves the qualify state at that point.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        deb_cnt <= '0;
      end else if ((state_next == QUAL_ON) || (state_next == QUAL_OFF)) begin
        deb_cnt <= (state_next == state) ? deb_cnt + CW'(1) : CW'(1);
      end else begin
        deb_cnt <= '0;
      end
    end

    // Pulse generator: loaded on entry to PRESENT, then runs down regardless
    // of what the FSM does afterwards.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        pulse_cnt <= '0;
      end else if (enter_present) begin
        pulse_cnt <= PULSE_LEN;
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - CW'(1);
      end
    end

    // Stuck watchdog: counts occupied clocks since the vehicle was accepted,
    // saturating at STUCK_CYCLES. The fault flag is set on the clock the
    // count reaches STUCK_CYCLES and cleared on the clock the channel goes
    // back to IDLE (clear wins if both happen together).
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        stuck_cnt <= '0;
        fault_q   <= 1'b0;
      end else begin
        if (enter_present) begin
          stuck_cnt <= '0;
        end else if (occ && (stuck_cnt != STUCK_MAX)) begin
          stuck_cnt <= stuck_cnt + CW'(1);
        end

        if (enter_idle) begin
          fault_q <= 1'b0;
        end else if (stuck_hit) begin
          fault_q <= 1'b1;
        end
      end
    end

    assign detect[i]   = (pulse_cnt != '0);
    assign occupied[i] = occ;
    assign fault[i]    = fault_q;
  end

endmodule

// File: tb/tb_vehicle_detect.sv
// -----------------------------------------------------------------------------
// tb_vehicle_detect
//
// Self-checking bench for vehicle_detect. A reference model, written in terms
// of "run lengths of disagreeing samples" rather than FSM states, predicts
// every change of detect/occupied/fault on every channel and pushes it into
// an expected queue as (cycle, channel, signal, new level). An independent
// monitor watches the DUT outputs and pops/compares one entry per observed
// change.
// -----------------------------------------------------------------------------
module tb_vehicle_detect;

  localparam int DEB   = 16;
  localparam int PULSE = 4;
  localparam int STUCK = 1000;
  localparam int CW    = 16;
  localparam int W     = 32;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic [3:0] raw = 4'h0;
  logic       detect_ns, detect_sn, detect_ew, detect_we;
  logic [3:0] fault, occupied;

  vehicle_detect #(
    .DEB_CYCLES  (DEB),
    .PULSE_CYCLES(PULSE),
    .STUCK_CYCLES(STUCK),
    .CW          (CW)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .sensor_ns(raw[0]),
    .sensor_sn(raw[1]),
    .sensor_ew(raw[2]),
    .sensor_we(raw[3]),
    .detect_ns(detect_ns),
    .detect_sn(detect_sn),
    .detect_ew(detect_ew),
    .detect_we(detect_we),
    .fault    (fault),
    .occupied (occupied)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Event word: {cycle, channel, signal (0 detect, 1 occupied, 2 fault), level}
  function automatic logic [W-1:0] ev(input int c, input int ch, input int sig,
                                      input logic lvl);
    logic [W-1:0] t;
    t = {27'(c), 2'(ch), 2'(sig), lvl};
    return t;
  endfunction

  task automatic check_val(input string name, input logic [W-1:0] act,
                           input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  logic [3:0] m_d1, m_d2, m_lvl;
  int         m_run  [4];
  int         m_rise [4];
  bit         m_has  [4];
  logic [3:0] e_lvl  [3];
  logic       m_x, m_new;

  task automatic clear_model();
    m_d1 = '0;
    m_d2 = '0;
    m_lvl = '0;
    for (int i = 0; i < 4; i++) begin
      m_run[i]  = 0;
      m_rise[i] = 0;
      m_has[i]  = 1'b0;
    end
    for (int s = 0; s < 3; s++) e_lvl[s] = '0;
  endtask

  // At each rising edge the loop level is flipped once DEB consecutive
  // synchronized samples (raw delayed two clocks) disagree with it. detect is
  // high for the first PULSE clocks after a rising flip; fault is high while
  // occupied once STUCK clocks have passed since that flip.
  always @(posedge clock) begin
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_x = m_d2[i];
        if (m_x != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i] = m_x;
            m_run[i] = 0;
            if (m_x) begin
              m_rise[i] = cyc;
              m_has[i]  = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
        for (int s = 0; s < 3; s++) begin
          case (s)
            0:       m_new = m_has[i] && ((cyc - m_rise[i]) < PULSE);
            1:       m_new = m_lvl[i];
            default: m_new = m_lvl[i] && m_has[i] && ((cyc - m_rise[i]) >= STUCK);
          endcase
          if (m_new != e_lvl[s][i]) begin
            exp_q.push_back(ev(cyc, i, s, m_new));
            e_lvl[s][i] = m_new;
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
  end

  // ---------------------------------------------------------------- monitor
  logic [3:0]   cur  [3];
  logic [3:0]   prev [3] = '{4'h0, 4'h0, 4'h0};
  logic [W-1:0] obs, want;

  always @(negedge clock) begin
    cur[0] = {detect_we, detect_ew, detect_sn, detect_ns};
    cur[1] = occupied;
    cur[2] = fault;
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < 3; s++) begin
        if (cur[s][i] !== prev[s][i]) begin
          obs = ev(cyc, i, s, cur[s][i]);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change: got cyc=%0d ch=%0d sig=%0d lvl=%0b, required no change",
                     cyc, i, s, cur[s][i]);
          end else begin
            want = exp_q.pop_front();
            if (obs !== want) begin
              n_fail++;
              $display("FAIL output_event: got cyc=%0d ch=%0d sig=%0d lvl=%0b, required cyc=%0d ch=%0d sig=%0d lvl=%0b",
                       obs[31:5], obs[4:3], obs[2:1], obs[0],
                       want[31:5], want[4:3], want[2:1], want[0]);
            end
          end
          prev[s][i] = cur[s][i];
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called between edges: predicts the asynchronous drop of every high output.
  task automatic assert_reset();
    for (int i = 0; i < 4; i++)
      for (int s = 0; s < 3; s++)
        if (e_lvl[s][i]) exp_q.push_back(ev(cyc, i, s, 1'b0));
    clear_model();
    rst_n = 1'b0;
    #1;
    check_val("reset_async_outputs",
              W'({fault, occupied, detect_we, detect_ew, detect_sn, detect_ns}), '0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  int hold [4];
  int k;

  // ---------------------------------------------------------------- stimulus
  initial begin
    clear_model();

    // Reset with every loop occupied, then release: one pulse per channel.
    rst_n = 1'b0;
    raw   = 4'hF;
    run(5);
    check_val("reset_hold_outputs",
              W'({fault, occupied, detect_we, detect_ew, detect_sn, detect_ns}), '0);
    release_reset();
    run(40);
    raw = 4'h0;
    run(40);

    // Clean car on ns.
    raw[0] = 1'b1; run(100);
    raw[0] = 1'b0; run(40);

    // Glitches on sn: short spike, car with dropout, two close cars.
    raw[1] = 1'b1; run(15);
    raw[1] = 1'b0; run(40);
    raw[1] = 1'b1; run(50);
    raw[1] = 1'b0; run(10);
    raw[1] = 1'b1; run(50);
    raw[1] = 1'b0; run(40);
    raw[1] = 1'b1; run(50);
    raw[1] = 1'b0; run(20);
    raw[1] = 1'b1; run(50);
    raw[1] = 1'b0; run(40);

    // All four channels together.
    raw = 4'hF; run(60);
    raw = 4'h0; run(40);

    // Stuck ew, release, then a normal car.
    raw[2] = 1'b1; run(1200);
    raw[2] = 1'b0; run(40);
    raw[2] = 1'b1; run(50);
    raw[2] = 1'b0; run(40);

    // Randomized traffic: independent hold times mix glitches, dropouts, cars.
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 40);
    repeat (2000) begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          raw[i]  = ~raw[i];
          hold[i] = $urandom_range(1, 40);
        end
      end
    end
    raw = 4'h0;
    run(60);

    // Reset two clocks into a we pulse; release with the loop empty.
    raw[3] = 1'b1;
    k = 0;
    while (!e_lvl[0][3] && k < 60) begin
      @(negedge clock);
      k++;
    end
    check_val("we_pulse_started", W'(e_lvl[0][3]), W'(1));
    @(posedge clock);
    @(posedge clock);
    #2;
    raw[3] = 1'b0;
    assert_reset();
    run(3);
    release_reset();
    run(60);

    // Everything predicted must have been observed.
    check_val("expected_queue_drained", W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vehicle_detect.md
# vehicle_detect

Conditions the four raw inductive-loop sensor inputs of the intersection and produces the clean `detect_ns`, `detect_sn`, `detect_ew`, `detect_we` signals consumed by the car counters in the visualization path. Each channel synchronizes its raw input, debounces both edges, and emits exactly one fixed-width high pulse per vehicle. A watchdog raises a per-channel fault flag when a loop stays occupied too long. The block sits directly upstream of the per-direction car counters, in the same clock domain as the system clock.

## Interface
- `DEB_CYCLES`, 16: consecutive identical synchronized samples needed to accept an edge (≥2).
- `PULSE_CYCLES`, 4: width of each detect pulse in clocks (1 ≤ PULSE_CYCLES < 2·DEB_CYCLES).
- `STUCK_CYCLES`, 1000: continuous occupancy, in clocks, that sets the fault flag (> DEB_CYCLES).
- `CW`, 16: internal counter width; must hold STUCK_CYCLES.

- `clock`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sensor_ns`, `sensor_sn`, `sensor_ew`, `sensor_we`  in  1 each  raw loop inputs, asynchronous, high = metal present.
- `detect_ns`, `detect_sn`, `detect_ew`, `detect_we`  out  1 each  clean vehicle pulses to the car counters.
- `fault`  out  4  stuck-loop flags, bit order {we, ew, sn, ns} = [3:0] ↔ [we, ew, sn, ns] with ns at bit 0.
- `occupied`  out  4  debounced loop occupancy, same bit order.

## Operation
- Four identical, independent channels; no shared state.
- Each raw input passes a 2-flop synchronizer; `s` denotes the synchronizer output.
- Per-channel FSM:
  - IDLE: debounce counter 0. `s`=1 → QUAL_ON, counter=1.
  - QUAL_ON: `s`=1 increments the counter; reaching DEB_CYCLES → PRESENT, start pulse, clear stuck counter. `s`=0 → IDLE, counter 0. No pulse is emitted.
  - PRESENT: `occupied`=1. `s`=0 → QUAL_OFF, counter=1.
  - QUAL_OFF: `occupied`=1. `s`=0 increments the counter; reaching DEB_CYCLES → IDLE. `s`=1 → PRESENT with no new pulse; this is treated as the same vehicle.
- Pulse generator: on entry to PRESENT, `detect`=1 for exactly PULSE_CYCLES clocks, independent of later FSM state.
- Stuck watchdog:
  - The stuck counter increments in PRESENT and QUAL_OFF and saturates at STUCK_CYCLES.
  - When it reaches STUCK_CYCLES, `fault` sets and stays set.
  - `fault` clears on the clock the channel enters IDLE.
  - While `fault`=1, no new pulses are possible because the channel never leaves occupancy.
- All counters saturate; none wrap.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - All FSMs go to IDLE and all counters clear.
  - Synchronizer flops clear.
  - `detect`=0, `fault`=0, `occupied`=0 immediately, without waiting for a clock.
  - Asserting reset mid-pulse truncates the pulse.
  - After release, a loop that is already occupied is qualified as a new vehicle.
- Rise latency:
  - Raw input high and stable from before edge k → `s`=1 after edge k+1.
  - `detect` and `occupied` rise after edge k+1+DEB_CYCLES (2+DEB_CYCLES clocks).
- Fall latency: `occupied` falls 2+DEB_CYCLES clocks after the raw input goes low and stays low.
- Glitch rejection:
  - A high glitch shorter than DEB_CYCLES synchronized samples produces no pulse.
  - A low dropout shorter than DEB_CYCLES produces no second pulse.
- Minimum spacing between two pulses on one channel is 2·DEB_CYCLES clocks, so pulses never merge.
- Simultaneous vehicles on all four channels produce four independent, cycle-aligned pulses.
- Fault timing: `fault` rises STUCK_CYCLES clocks after `detect` rose.

## Test plan
- Reset: hold `rst_n`=0 with all sensors high → all outputs 0. Release, sensors still high → one 4-clock pulse per channel, 18 clocks after release.
- Clean car on ns: raw high for 100 clocks → `detect_ns` high for exactly 4 clocks starting 18 clocks after the rise. `occupied[0]` high until 18 clocks after the fall. Other channels stay idle.
- Glitches on sn: 15-clock high pulse → no detect. Car with a 10-clock dropout mid-body → exactly one pulse. Two cars separated by 20 low clocks → two pulses.
- All four channels rise on the same clock → four identical pulses on the same cycle, with correct fault/occupied bit mapping.
- Stuck ew: raw held high 1200 clocks → `fault[2]` rises 1000 clocks after `detect_ew` rose. After the release, `fault[2]` clears 18 clocks after the fall, and the next car gives a normal pulse.
- Mid-pulse reset: assert `rst_n`=0 two clocks into a `detect_we` pulse → `detect_we` drops asynchronously. Release with the sensor low → no further pulse.
